// File: rtl/avalon_pio_poller_pkg.sv
// Shared definitions for the switch-to-LED PIO poller.
//   state_e     : poller FSM state encoding
//   PioRegData  : word offset of the data register inside an Avalon PIO
//   AvmDataW    : Avalon data bus width
package avalon_pio_poller_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdReq,
      StRdWait,
      StCmp,
      StWrReq
   } state_e;

   localparam int unsigned PioRegData = 0;
   localparam int unsigned AvmDataW   = 32;

   // Byte address of a PIO register given its base and word offset.
   function automatic logic [31:0] pio_reg_addr(input logic [31:0] base, input int unsigned word);
      return base + 32'(word * 4);
   endfunction

endpackage

// File: rtl/pio_poll_timer.sv
// Free-running poll tick generator.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   tick_o  : high for one cycle every POLL_DIV cycles; first tick POLL_DIV cycles after reset
module pio_poll_timer #(
   parameter int unsigned POLL_DIV = 50000
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick_o
);

   localparam int unsigned     CntW   = $clog2(POLL_DIV);
   localparam logic [CntW-1:0] Reload = CntW'(POLL_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == '0) ? Reload : cnt_q - CntW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= Reload;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/avalon_pio_poller.sv
// Avalon-MM master that polls a switch PIO and mirrors its value into an LED PIO.
// A write is issued only when the sampled value differs from the last one written;
// the first poll after reset always writes.
//   clk, reset_n          : clock, asynchronous active-low reset
//   enable_i              : start new polls on ticks when high
//   avm_*                 : Avalon-MM master port (one transaction outstanding at most)
//   last_value_o          : value most recently written to the LED PIO
//   changed_o             : one-cycle pulse after an LED write is accepted
//   missed_tick_o         : one-cycle pulse after a tick arrived while busy
module avalon_pio_poller
   import avalon_pio_poller_pkg::*;
#(
   parameter int unsigned       DATA_W   = 10,
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] SRC_ADDR = ADDR_W'(32'h0000_0000),
   parameter logic [ADDR_W-1:0] DST_ADDR = ADDR_W'(32'h0000_0010),
   parameter int unsigned       POLL_DIV = 50000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable_i,
   output logic [ADDR_W-1:0]   avm_address_o,
   output logic                avm_read_o,
   output logic                avm_write_o,
   output logic [AvmDataW-1:0] avm_writedata_o,
   input  logic [AvmDataW-1:0] avm_readdata_i,
   input  logic                avm_readdatavalid_i,
   input  logic                avm_waitrequest_i,
   output logic [DATA_W-1:0]   last_value_o,
   output logic                changed_o,
   output logic                missed_tick_o
);

   localparam logic [ADDR_W-1:0] SrcDataAddr = ADDR_W'(pio_reg_addr(32'(SRC_ADDR), PioRegData));
   localparam logic [ADDR_W-1:0] DstDataAddr = ADDR_W'(pio_reg_addr(32'(DST_ADDR), PioRegData));

   state_e                state_q;
   logic [ADDR_W-1:0]     address_q;
   logic                  read_q;
   logic                  write_q;
   logic [AvmDataW-1:0]   writedata_q;
   logic [DATA_W-1:0]     sample_q;
   logic [DATA_W-1:0]     last_value_q;
   logic                  first_done_q;
   logic                  changed_q;
   logic                  missed_tick_q;
   logic                  tick;

   // Upper read-data bits carry nothing for a DATA_W-wide PIO.
   logic unused_rdata_hi;
   assign unused_rdata_hi = ^avm_readdata_i[AvmDataW-1:DATA_W];

   pio_poll_timer #(
      .POLL_DIV (POLL_DIV)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .tick_o  (tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         address_q     <= '0;
         read_q        <= 1'b0;
         write_q       <= 1'b0;
         writedata_q   <= '0;
         sample_q      <= '0;
         last_value_q  <= '0;
         first_done_q  <= 1'b0;
         changed_q     <= 1'b0;
         missed_tick_q <= 1'b0;
      end else begin
         changed_q     <= 1'b0;
         missed_tick_q <= tick && (state_q != StIdle);
         unique case (state_q)
            StIdle: begin
               if (tick && enable_i) begin
                  state_q   <= StRdReq;
                  address_q <= SrcDataAddr;
                  read_q    <= 1'b1;
               end
            end
            StRdReq: begin
               if (!avm_waitrequest_i) begin
                  read_q <= 1'b0;
                  // Zero-latency slaves return data in the accept cycle.
                  if (avm_readdatavalid_i) begin
                     sample_q <= avm_readdata_i[DATA_W-1:0];
                     state_q  <= StCmp;
                  end else begin
                     state_q <= StRdWait;
                  end
               end
            end
            StRdWait: begin
               if (avm_readdatavalid_i) begin
                  sample_q <= avm_readdata_i[DATA_W-1:0];
                  state_q  <= StCmp;
               end
            end
            StCmp: begin
               if (!first_done_q || (sample_q != last_value_q)) begin
                  state_q     <= StWrReq;
                  address_q   <= DstDataAddr;
                  writedata_q <= {{(AvmDataW - DATA_W){1'b0}}, sample_q};
                  write_q     <= 1'b1;
               end else begin
                  state_q <= StIdle;
               end
            end
            StWrReq: begin
               if (!avm_waitrequest_i) begin
                  write_q      <= 1'b0;
                  last_value_q <= sample_q;
                  first_done_q <= 1'b1;
                  changed_q    <= 1'b1;
                  state_q      <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
               read_q  <= 1'b0;
               write_q <= 1'b0;
            end
         endcase
      end
   end

   assign avm_address_o   = address_q;
   assign avm_read_o      = read_q;
   assign avm_write_o     = write_q;
   assign avm_writedata_o = writedata_q;
   assign last_value_o    = last_value_q;
   assign changed_o       = changed_q;
   assign missed_tick_o   = missed_tick_q;

endmodule

// File: tb/tb_avalon_pio_poller.sv
// Directed bench for avalon_pio_poller with a small behavioural Avalon slave.
module tb_avalon_pio_poller;

   localparam int unsigned DATA_W   = 10;
   localparam int unsigned POLL_DIV = 8;
   localparam logic [31:0] SRC      = 32'h0000_0000;
   localparam logic [31:0] DST      = 32'h0000_0010;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;
   logic        avm_waitrequest;
   logic [9:0]  last_value;
   logic        changed;
   logic        missed_tick;

   int checks = 0;
   int failures = 0;

   // Slave configuration, driven by the tests.
   int         rd_wait = 0;
   int         wr_wait = 0;
   int         rdv_lat = 1;
   logic [9:0] sw_val = 10'h155;

   int stall_q = 0;
   int rdv_cnt = 0;

   // Monitor state.
   int          rd_acc = 0;
   int          wr_acc = 0;
   int          chg_cnt = 0;
   int          miss_cnt = 0;
   logic        overlap = 1'b0;
   logic [31:0] wr_addr_seen = '0;
   logic [31:0] wr_data_seen = '0;

   always #5 clk = ~clk;

   avalon_pio_poller #(
      .DATA_W   (DATA_W),
      .ADDR_W   (32),
      .SRC_ADDR (SRC),
      .DST_ADDR (DST),
      .POLL_DIV (POLL_DIV)
   ) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .enable_i            (enable),
      .avm_address_o       (avm_address),
      .avm_read_o          (avm_read),
      .avm_write_o         (avm_write),
      .avm_writedata_o     (avm_writedata),
      .avm_readdata_i      (avm_readdata),
      .avm_readdatavalid_i (avm_readdatavalid),
      .avm_waitrequest_i   (avm_waitrequest),
      .last_value_o        (last_value),
      .changed_o           (changed),
      .missed_tick_o       (missed_tick)
   );

   // Junk in the upper bits must never reach the LED value.
   assign avm_readdata      = {22'h35A5A5, sw_val};
   assign avm_waitrequest   = (avm_read && (stall_q < rd_wait)) || (avm_write && (stall_q < wr_wait));
   assign avm_readdatavalid = (rdv_cnt == 1);

   always @(posedge clk) begin
      if ((avm_read || avm_write) && avm_waitrequest) stall_q <= stall_q + 1;
      else stall_q <= 0;
      if (avm_read && !avm_waitrequest) rdv_cnt <= rdv_lat;
      else if (rdv_cnt > 0) rdv_cnt <= rdv_cnt - 1;
   end

   always @(posedge clk) begin
      if (avm_read && !avm_waitrequest) rd_acc <= rd_acc + 1;
      if (avm_write && !avm_waitrequest) begin
         wr_acc       <= wr_acc + 1;
         wr_addr_seen <= avm_address;
         wr_data_seen <= avm_writedata;
      end
      if (changed) chg_cnt <= chg_cnt + 1;
      if (missed_tick) miss_cnt <= miss_cnt + 1;
      if (avm_read && avm_write) overlap <= 1'b1;
   end

   // Waits (bounded) at negedges until the selected output is high.
   // sel: 0 = avm_read, 1 = avm_write, 2 = changed
   task automatic wait_high(input int sel, input int budget, output bit ok, output int waited);
      bit hit;
      ok = 1'b0;
      waited = 0;
      while (waited < budget) begin
         case (sel)
            0: hit = avm_read;
            1: hit = avm_write;
            default: hit = changed;
         endcase
         if (hit) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         waited++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable  = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (avm_read !== 1'b0) begin failures++; $display("FAIL rst_read got=%b exp=0", avm_read); end
      checks++; if (avm_write !== 1'b0) begin failures++; $display("FAIL rst_write got=%b exp=0", avm_write); end
      checks++; if (avm_address !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", avm_address); end
      checks++; if (avm_writedata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", avm_writedata); end
      checks++; if (last_value !== 10'h0) begin failures++; $display("FAIL rst_last got=%h exp=0", last_value); end
      checks++; if (changed !== 1'b0) begin failures++; $display("FAIL rst_changed got=%b exp=0", changed); end
      checks++; if (missed_tick !== 1'b0) begin failures++; $display("FAIL rst_missed got=%b exp=0", missed_tick); end
   endtask

   task automatic test_first_poll();
      int first_rd = 0, first_wr = 0, first_chg = 0;
      logic [31:0] ra = '1, wa = '0, wd = '0;
      reset_n = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (avm_read && first_rd == 0) begin first_rd = i; ra = avm_address; end
         if (avm_write && first_wr == 0) begin first_wr = i; wa = avm_address; wd = avm_writedata; end
         if (changed && first_chg == 0) first_chg = i;
      end
      checks++; if (first_rd != 8) begin failures++; $display("FAIL first_read_cycle got=%0d exp=8", first_rd); end
      checks++; if (ra !== SRC) begin failures++; $display("FAIL first_read_addr got=%h exp=%h", ra, SRC); end
      checks++; if (first_wr != 11) begin failures++; $display("FAIL first_write_cycle got=%0d exp=11", first_wr); end
      checks++; if (wa !== DST) begin failures++; $display("FAIL first_write_addr got=%h exp=%h", wa, DST); end
      checks++; if (wd !== 32'h155) begin failures++; $display("FAIL first_write_data got=%h exp=155", wd); end
      checks++; if (first_chg != 12) begin failures++; $display("FAIL first_changed_cycle got=%0d exp=12", first_chg); end
      checks++; if (last_value !== 10'h155) begin failures++; $display("FAIL first_last got=%h exp=155", last_value); end
   endtask

   task automatic test_same_value();
      int r0 = rd_acc, w0 = wr_acc, c0 = chg_cnt, n;
      bit ok;
      wait_high(0, 20, ok, n);
      checks++; if (!ok) begin failures++; $display("FAIL same_read_timeout got=none exp=read"); end
      repeat (6) @(negedge clk);
      checks++; if (rd_acc - r0 != 1) begin failures++; $display("FAIL same_reads got=%0d exp=1", rd_acc - r0); end
      checks++; if (wr_acc != w0) begin failures++; $display("FAIL same_writes got=%0d exp=0", wr_acc - w0); end
      checks++; if (chg_cnt != c0) begin failures++; $display("FAIL same_changed got=%0d exp=0", chg_cnt - c0); end
   endtask

   task automatic test_waitrequest();
      int n;
      bit ok, stable;
      sw_val  = 10'h2AA;
      rd_wait = 3;
      wr_wait = 3;
      wait_high(0, 20, ok, n);
      checks++; if (!ok) begin failures++; $display("FAIL wait_read_timeout got=none exp=read"); end
      stable = 1'b1; n = 0;
      while (avm_read && n < 20) begin
         if (avm_address !== SRC) stable = 1'b0;
         n++;
         @(negedge clk);
      end
      checks++; if (n != 4 || !stable) begin failures++; $display("FAIL wait_read_hold got=%0d/%b exp=4/1", n, stable); end
      wait_high(1, 20, ok, n);
      checks++; if (!ok) begin failures++; $display("FAIL wait_write_timeout got=none exp=write"); end
      stable = 1'b1; n = 0;
      while (avm_write && n < 20) begin
         if (avm_address !== DST || avm_writedata !== 32'h2AA) stable = 1'b0;
         n++;
         @(negedge clk);
      end
      checks++; if (n != 4 || !stable) begin failures++; $display("FAIL wait_write_hold got=%0d/%b exp=4/1", n, stable); end
      checks++; if (changed !== 1'b1) begin failures++; $display("FAIL wait_changed got=%b exp=1", changed); end
      checks++; if (last_value !== 10'h2AA) begin failures++; $display("FAIL wait_last got=%h exp=2aa", last_value); end
   endtask

   task automatic test_slow_rdv();
      int r0, w0, m0, n;
      bit ok;
      rd_wait = 0;
      wr_wait = 0;
      rdv_lat = 20;
      sw_val  = 10'h0F0;
      r0 = rd_acc; w0 = wr_acc; m0 = miss_cnt;
      wait_high(0, 20, ok, n);
      checks++; if (!ok) begin failures++; $display("FAIL slow_read_timeout got=none exp=read"); end
      wait_high(2, 60, ok, n);
      checks++; if (!ok) begin failures++; $display("FAIL slow_changed_timeout got=none exp=changed"); end
      checks++; if (rd_acc - r0 != 1) begin failures++; $display("FAIL slow_reads got=%0d exp=1", rd_acc - r0); end
      checks++; if (wr_acc - w0 != 1) begin failures++; $display("FAIL slow_writes got=%0d exp=1", wr_acc - w0); end
      checks++; if (miss_cnt - m0 != 2) begin failures++; $display("FAIL slow_missed got=%0d exp=2", miss_cnt - m0); end
      checks++; if (wr_data_seen !== 32'h0F0) begin failures++; $display("FAIL slow_wdata got=%h exp=f0", wr_data_seen); end
      checks++; if (last_value !== 10'h0F0) begin failures++; $display("FAIL slow_last got=%h exp=f0", last_value); end
   endtask

   task automatic test_enable();
      int r0, m0, w0, hi = 0, n;
      bit ok;
      enable  = 1'b0;
      rdv_lat = 1;
      r0 = rd_acc; m0 = miss_cnt;
      repeat (30) begin
         @(negedge clk);
         if (avm_read) hi++;
      end
      checks++; if (hi != 0 || rd_acc != r0) begin failures++; $display("FAIL en_off_reads got=%0d exp=0", hi); end
      checks++; if (miss_cnt != m0) begin failures++; $display("FAIL en_off_missed got=%0d exp=0", miss_cnt - m0); end
      sw_val  = 10'h333;
      wr_wait = 5;
      enable  = 1'b1;
      wait_high(1, 40, ok, n);
      checks++; if (!ok) begin failures++; $display("FAIL en_write_timeout got=none exp=write"); end
      enable = 1'b0;
      w0 = wr_acc;
      n = 0;
      while (avm_write && n < 20) begin @(negedge clk); n++; end
      checks++; if (wr_acc - w0 != 1) begin failures++; $display("FAIL en_drop_write got=%0d exp=1", wr_acc - w0); end
      checks++; if (wr_data_seen !== 32'h333) begin failures++; $display("FAIL en_drop_wdata got=%h exp=333", wr_data_seen); end
      checks++; if (last_value !== 10'h333) begin failures++; $display("FAIL en_drop_last got=%h exp=333", last_value); end
      r0 = rd_acc;
      repeat (20) @(negedge clk);
      checks++; if (rd_acc != r0) begin failures++; $display("FAIL en_after_reads got=%0d exp=0", rd_acc - r0); end
   endtask

   task automatic test_reset_mid();
      int w0, c0, n;
      bit ok;
      wr_wait = 0;
      rdv_lat = 10;
      sw_val  = 10'h000;
      enable  = 1'b1;
      wait_high(0, 20, ok, n);
      checks++; if (!ok) begin failures++; $display("FAIL rmid_read_timeout got=none exp=read"); end
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++; if (avm_read !== 1'b0 || avm_write !== 1'b0) begin
         failures++; $display("FAIL rmid_rw got=%b%b exp=00", avm_read, avm_write);
      end
      checks++; if (avm_address !== 32'h0) begin failures++; $display("FAIL rmid_addr got=%h exp=0", avm_address); end
      checks++; if (last_value !== 10'h0) begin failures++; $display("FAIL rmid_last got=%h exp=0", last_value); end
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      w0 = wr_acc; c0 = chg_cnt;
      wait_high(0, 20, ok, n);
      checks++; if (!ok || n != 8) begin failures++; $display("FAIL rmid_first_read got=%0d exp=8", n); end
      checks++; if (wr_acc != w0 || chg_cnt != c0) begin
         failures++; $display("FAIL rmid_stale got=%0d writes exp=0", wr_acc - w0);
      end
      wait_high(2, 40, ok, n);
      checks++; if (!ok) begin failures++; $display("FAIL rmid_changed_timeout got=none exp=changed"); end
      checks++; if (wr_acc - w0 != 1) begin failures++; $display("FAIL rmid_writes got=%0d exp=1", wr_acc - w0); end
      checks++; if (wr_addr_seen !== DST || wr_data_seen !== 32'h0) begin
         failures++; $display("FAIL rmid_wr got=%h/%h exp=%h/0", wr_addr_seen, wr_data_seen, DST);
      end
   endtask

   task automatic test_no_overlap();
      checks++; if (overlap !== 1'b0) begin failures++; $display("FAIL rd_wr_overlap got=%b exp=0", overlap); end
   endtask

   initial begin
      test_reset();
      test_first_poll();
      test_same_value();
      test_waitrequest();
      test_slow_rdv();
      test_enable();
      test_reset_mid();
      test_no_overlap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
